// File: rtl/lsu_pkg.sv
// Shared types and access-type decoding for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned-extension variants exist only for loads.
  function automatic logic access_legal(input logic is_store, input logic [2:0] f3,
                                        input logic [1:0] off);
    logic legal;
    legal = 1'b0;
    unique case (f3)
      F3_B:    legal = 1'b1;
      F3_H:    legal = !off[0];
      F3_W:    legal = (off == 2'b00);
      F3_BU:   legal = !is_store;
      F3_HU:   legal = !is_store && !off[0];
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    unique case (f3[1:0])
      2'b00:   be = 4'(4'b0001 << off);
      2'b01:   be = 4'(4'b0011 << off);
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed lane of a read word and sign/zero-extends it to XLEN.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      off_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] result_o
);

  logic [XLEN-1:0] lane;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;

  assign lane   = rdata_i >> {off_i, 3'b000};
  assign lane_b = lane[7:0];
  assign lane_h = lane[15:0];

  always_comb begin
    result_o = rdata_i;
    unique case (funct3_i)
      F3_B:    result_o = {{(XLEN-8){lane_b[7]}}, lane_b};
      F3_H:    result_o = {{(XLEN-16){lane_h[15]}}, lane_h};
      F3_BU:   result_o = {{(XLEN-8){1'b0}}, lane_b};
      F3_HU:   result_o = {{(XLEN-16){1'b0}}, lane_h};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding access, stalls the core until writeback.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            is_store_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [REGW-1:0] rd_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            rf_we_o,
  output logic [REGW-1:0] rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o,
  output logic            stall_o,
  output logic            err_o
);

  lsu_state_e      state_q;
  logic            is_store_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] store_data_q;
  logic [REGW-1:0] rd_q;
  logic [XLEN-1:0] rdata_q;

  logic            req_legal;
  logic            in_idle;
  logic [XLEN-1:0] load_result;

  assign in_idle   = (state_q == S_IDLE);
  assign req_legal = access_legal(is_store_i, funct3_i, addr_i[1:0]);

  lsu_load_align #(.XLEN(XLEN)) u_load_align (
    .rdata_i  (mem_rdata_i),
    .off_i    (addr_q[1:0]),
    .funct3_i (funct3_q),
    .result_o (load_result)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      store_data_q <= '0;
      rd_q         <= '0;
      rdata_q      <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid_i && req_legal) begin
            is_store_q   <= is_store_i;
            funct3_q     <= funct3_i;
            addr_q       <= addr_i;
            store_data_q <= store_data_i;
            rd_q         <= rd_i;
            state_q      <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_gnt_i) state_q <= is_store_q ? S_DONE : S_WAIT;
        end
        S_WAIT: begin
          if (mem_rvalid_i) begin
            rdata_q <= load_result;
            state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = in_idle;
  assign err_o       = in_idle && req_valid_i && !req_legal;
  assign stall_o     = (state_q == S_REQ) || (state_q == S_WAIT) ||
                       (in_idle && req_valid_i && req_legal);

  // Memory side is a pure function of the latched request, so it is stable until grant.
  assign mem_req_o  = (state_q == S_REQ);
  assign mem_we_o   = (state_q == S_REQ) && is_store_q;
  assign mem_be_o   = (state_q == S_REQ) ? byte_enables(funct3_q, addr_q[1:0]) : 4'b0000;
  assign mem_addr_o = {addr_q[XLEN-1:2], 2'b00};

  always_comb begin
    mem_wdata_o = store_data_q;
    unique case (funct3_q[1:0])
      2'b00:   mem_wdata_o = {(XLEN/8){store_data_q[7:0]}};
      2'b01:   mem_wdata_o = {(XLEN/16){store_data_q[15:0]}};
      default: mem_wdata_o = store_data_q;
    endcase
  end

  assign rf_we_o    = (state_q == S_DONE) && !is_store_q && (rd_q != '0);
  assign rf_waddr_o = rd_q;
  assign rf_wdata_o = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized checks of load_store_unit against an arithmetic access model.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall;
  logic        err;

  int n_pass;
  int n_total;

  load_store_unit #(.XLEN(32), .REGW(5)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .is_store_i   (is_store),
    .funct3_i     (funct3),
    .addr_i       (addr),
    .store_data_i (store_data),
    .rd_i         (rd),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_be_o     (mem_be),
    .mem_wdata_o  (mem_wdata),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .rf_we_o      (rf_we),
    .rf_waddr_o   (rf_waddr),
    .rf_wdata_o   (rf_wdata),
    .stall_o      (stall),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: access rules written as plain arithmetic.
  function automatic int access_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    if (st && f3 > 3'd2) return 1'b0;
    sz = access_size(f3);
    return (a % sz) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = access_size(f3);
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (access_size(f3))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rdat);
    longint v;
    longint lim;
    logic [31:0] shifted;
    int sz;
    sz = access_size(f3);
    if (sz == 4) return rdat;
    shifted = rdat >> (8 * (a % 4));
    lim = longint'(1) << (8 * sz);
    v = longint'(shifted) % lim;
    if (f3 < 3'd4 && v >= lim / 2) v = v - lim;
    return 32'(v);
  endfunction

  // One complete access as seen by the core and memory, with checks each cycle.
  task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [4:0] r,
                        input logic [31:0] rdat, input int gdel, input int rdel);
    bit legal;
    legal = m_legal(st, f3, a);
    @(posedge clk); #1;
    req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd; rd = r;
    @(negedge clk);
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("idle_err", 32'(err), 32'(!legal));
    chk("idle_stall", 32'(stall), 32'(legal));
    chk("idle_memreq", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    addr = $urandom; store_data = $urandom; rd = 5'($urandom); funct3 = 3'($urandom);
    is_store = 1'($urandom);
    if (!legal) begin
      @(negedge clk);
      chk("illegal_ready", 32'(req_ready), 32'd1);
      chk("illegal_err", 32'(err), 32'd0);
      chk("illegal_memreq", 32'(mem_req), 32'd0);
      chk("illegal_rfwe", 32'(rf_we), 32'd0);
      return;
    end
    for (int i = 0; i <= gdel; i++) begin
      mem_gnt = (i == gdel);
      mem_rvalid = (i != gdel) ? 1'($urandom) : 1'b0;
      mem_rdata = $urandom;
      @(negedge clk);
      chk("req_memreq", 32'(mem_req), 32'd1);
      chk("req_we", 32'(mem_we), 32'(st));
      chk("req_addr", mem_addr, a & 32'hFFFF_FFFC);
      chk("req_be", 32'(mem_be), 32'(m_be(f3, a)));
      if (st) chk("req_wdata", mem_wdata, m_wdata(f3, sd));
      chk("req_stall", 32'(stall), 32'd1);
      chk("req_ready", 32'(req_ready), 32'd0);
      chk("req_rfwe", 32'(rf_we), 32'd0);
      @(posedge clk); #1;
    end
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    if (!st) begin
      for (int i = 0; i <= rdel; i++) begin
        mem_rvalid = (i == rdel);
        mem_rdata = (i == rdel) ? rdat : $urandom;
        @(negedge clk);
        chk("wait_stall", 32'(stall), 32'd1);
        chk("wait_memreq", 32'(mem_req), 32'd0);
        chk("wait_rfwe", 32'(rf_we), 32'd0);
        @(posedge clk); #1;
      end
      mem_rvalid = 1'b0;
      mem_rdata = $urandom;
    end
    @(negedge clk);
    chk("done_stall", 32'(stall), 32'd0);
    chk("done_memreq", 32'(mem_req), 32'd0);
    chk("done_be", 32'(mem_be), 32'd0);
    chk("done_rfwe", 32'(rf_we), 32'(!st && r != 5'd0));
    if (!st && r != 5'd0) begin
      chk("done_waddr", 32'(rf_waddr), 32'(r));
      chk("done_wdata", rf_wdata, m_load(f3, a, rdat));
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'b000; addr = '0;
    store_data = '0; rd = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_outs", 32'({mem_req, mem_we, mem_be, rf_we, stall, err}), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rf", {rf_wdata[26:0], rf_waddr}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed scenarios.
    access(1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 32'hDEAD_BEEF, 0, 0);
    chk("lw_wdata_const", rf_wdata, 32'hDEAD_BEEF);
    access(1'b0, 3'b000, 32'h103, 32'h0, 5'd7, 32'h80FF_FF7F, 0, 0);
    chk("lb_const", rf_wdata, 32'hFFFF_FF80);
    access(1'b0, 3'b100, 32'h103, 32'h0, 5'd7, 32'h80FF_FF7F, 1, 2);
    chk("lbu_const", rf_wdata, 32'h0000_0080);
    access(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 5'd3, 32'h0, 3, 0);
    access(1'b0, 3'b010, 32'h101, 32'h0, 5'd4, 32'h0, 0, 0);
    access(1'b0, 3'b011, 32'h100, 32'h0, 5'd4, 32'h0, 0, 0);
    access(1'b1, 3'b100, 32'h100, 32'h0, 5'd4, 32'h0, 0, 0);
    access(1'b0, 3'b001, 32'h106, 32'h0, 5'd0, 32'h8765_4321, 1, 1);
    access(1'b0, 3'b101, 32'h102, 32'h0, 5'd9, 32'h8765_4321, 0, 0);

    // Reset while waiting for read data; a late rvalid must not write back.
    @(posedge clk); #1;
    req_valid = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h300; rd = 5'd11;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("rstwait_ready", 32'(req_ready), 32'd1);
    chk("rstwait_rfwe", 32'(rf_we), 32'd0);
    chk("rstwait_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("rstwait_rfwe2", 32'(rf_we), 32'd0);
    chk("rstwait_ready2", 32'(req_ready), 32'd1);

    // Randomized accesses.
    for (int k = 0; k < 300; k++) begin
      logic [31:0] ra;
      ra = 32'($urandom) & 32'h0000_FFFF;
      access(1'($urandom), 3'($urandom), ra, $urandom, 5'($urandom), $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the data and address width.
REQ-002 Parameter REGW, default 5, SHALL set the destination register index width.
REQ-003 clk_i  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_ni  in  1  SHALL be the synchronous, active-low reset.
REQ-005 req_valid_i  in  1  SHALL mean the core presents a memory instruction.
REQ-006 req_ready_o  out  1  SHALL mean the unit accepts a request this cycle.
REQ-007 is_store_i  in  1  SHALL select store (1) or load (0).
REQ-008 funct3_i  in  3  SHALL carry the RV32I access type: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
REQ-009 addr_i  in  XLEN  SHALL carry the byte address.
REQ-010 store_data_i  in  XLEN  SHALL carry the store source (rs2).
REQ-011 rd_i  in  REGW  SHALL carry the load destination index.
REQ-012 mem_req_o, mem_we_o  out  1 each  SHALL be the memory request and the write flag.
REQ-013 mem_addr_o  out  XLEN  SHALL be the word-aligned address.
REQ-014 mem_be_o  out  4  SHALL be the byte enables.
REQ-015 mem_wdata_o  out  XLEN  SHALL be the lane-replicated store data.
REQ-016 mem_gnt_i, mem_rvalid_i  in  1 each  SHALL be the memory grant and read-valid.
REQ-017 mem_rdata_i  in  XLEN  SHALL be the memory read data.
REQ-018 rf_we_o, rf_waddr_o, rf_wdata_o  out  1/REGW/XLEN  SHALL drive the register-file write port.
REQ-019 stall_o  out  1  SHALL hold the core's PC and pipeline while high.
REQ-020 err_o  out  1  SHALL be a one-cycle pulse flagging a misaligned or illegal access.

Function
REQ-021 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-022 req_ready_o SHALL equal (state==IDLE).
REQ-023 Error check in IDLE: an access SHALL be illegal when it is a halfword with addr_i[0]=1, a word with addr_i[1:0]!=0, or an unlisted funct3 (stores with funct3>010 are illegal).
REQ-024 IDLE with req_valid_i and illegal: err_o=1 and stall_o=0 combinationally, with no state change, no memory access and no writeback.
REQ-025 IDLE with req_valid_i and legal: the unit SHALL latch is_store, funct3, addr, store_data and rd, go to REQ, and drive stall_o=1.
REQ-026 REQ: mem_req_o=1, with all mem_* outputs driven from the latched request and held stable until mem_gnt_i.
REQ-027 REQ with mem_gnt_i: a store SHALL go to DONE and a load SHALL go to WAIT.
REQ-028 WAIT with mem_rvalid_i: the unit SHALL register the extracted data and go to DONE; mem_rvalid_i SHALL be ignored in every other state.
REQ-029 DONE: stall_o=0 and rf_we_o=(load && rd!=0), with rf_waddr_o=rd and rf_wdata_o=registered data; the next state SHALL be IDLE.
REQ-030 Minimum load latency: accept at cycle N, grant at N+1, rvalid at N+2, DONE/writeback at N+3; a store SHALL reach DONE at N+2.
REQ-031 stall_o SHALL be 1 in REQ and WAIT, 1 in IDLE for a legal valid request, and 0 otherwise.
REQ-032 mem_addr_o SHALL be {addr[XLEN-1:2],2'b00}.
REQ-033 Byte/halfword/word mem_be_o SHALL be 0001<<addr[1:0], 0011<<addr[1:0] and 1111 respectively.
REQ-034 Byte stores SHALL drive mem_wdata_o={4{data[7:0]}}, halfword stores {2{data[15:0]}}, and word stores data.
REQ-035 Load extraction SHALL select the lane by addr[1:0]; LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend.
REQ-036 Outside REQ, mem_req_o, mem_we_o and mem_be_o SHALL be 0.
REQ-037 Outside DONE, rf_we_o SHALL be 0.

Reset
REQ-038 While rst_ni=0 at a clock edge, state SHALL go to IDLE and all latched fields and registered data SHALL clear to 0.
REQ-039 After reset, every output SHALL be 0 except req_ready_o=1.
REQ-040 A reset in REQ or WAIT SHALL abandon the access, and a late mem_rvalid_i afterwards SHALL cause no writeback.

Structure
REQ-041 Package lsu_pkg SHALL hold the state enum and the funct3 localparams for the load and store widths.
REQ-042 Sub-module lsu_load_align SHALL be purely combinational (rdata, addr[1:0], funct3 -> extended XLEN result) and instantiated once.

Verification
REQ-043 LW, addr=0x100, rd=5: gnt at N+1 and rvalid at N+2 with rdata=0xDEADBEEF -> rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF at N+3, with stall_o=1 for N..N+2 and 0 at N+3.
REQ-044 LB, addr=0x103, rdata=0x80FF_FF7F -> rf_wdata_o=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-045 SH, addr=0x202, store_data=0x1234ABCD -> mem_be_o=1100, mem_wdata_o=0xABCDABCD, mem_addr_o=0x200, mem_we_o=1; gnt delayed 3 cycles -> outputs stable throughout and no rf_we_o.
REQ-046 LW at addr=0x101 -> err_o=1 for one cycle, mem_req_o never asserted, stall_o=0; funct3=011 load -> same response.
REQ-047 LH with rd=0 -> full handshake completes with rf_we_o=0 in DONE.
REQ-048 rst_ni=0 during WAIT, then rvalid=1 after release -> no rf_we_o, state IDLE, req_ready_o=1.
